// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an addi/bne subset: fetches over a req/valid
// handshake, decodes the IR and sequences ALU control, write-back and PC update.
module multicycle_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req,
   input  logic                  imem_valid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instr,
   input  logic                  EQ,
   output logic [2:0]            ALUctrl,
   output logic                  ALUsrc,
   output logic                  ImmSrc,
   output logic                  RegWrite,
   output logic                  PCen,
   output logic                  PCsrc,
   output logic                  illegal,
   output logic [CNT_WIDTH-1:0]  instret
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EX_ADDI,
      WB,
      EX_BNE,
      TRAP
   } state_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   logic                  illegal_q, illegal_d;
   logic [CNT_WIDTH-1:0]  instret_q, instret_d;

   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode  = ir_q[6:0];
   assign funct3  = ir_q[14:12];
   assign instr   = ir_q;
   assign illegal = illegal_q;
   assign instret = instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ir_q      <= DATA_WIDTH'(32'h0000_0013);
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      instret_d = instret_q;
      imem_req  = 1'b0;
      ALUctrl   = 3'b000;
      ALUsrc    = 1'b0;
      ImmSrc    = 1'b0;
      RegWrite  = 1'b0;
      PCen      = 1'b0;
      PCsrc     = 1'b0;

      unique case (state_q)
         IDLE: state_d = FETCH;

         FETCH: begin
            imem_req = 1'b1;
            if (imem_valid) begin
               ir_d    = imem_rdata;
               state_d = DECODE;
            end
         end

         DECODE: begin
            if (opcode == OP_IMM && funct3 == 3'b000) begin
               state_d = EX_ADDI;
            end else if (opcode == OP_BRANCH && funct3 == 3'b001) begin
               state_d = EX_BNE;
            end else begin
               state_d   = TRAP;
               illegal_d = 1'b1;
            end
         end

         EX_ADDI: begin
            ALUctrl = ALU_ADD;
            ALUsrc  = 1'b1;
            state_d = WB;
         end

         // Writes to x0 are suppressed here so the regfile never sees them.
         WB: begin
            ALUctrl   = ALU_ADD;
            ALUsrc    = 1'b1;
            RegWrite  = (ir_q[11:7] != 5'd0);
            PCen      = 1'b1;
            instret_d = instret_q + CNT_WIDTH'(1);
            state_d   = FETCH;
         end

         EX_BNE: begin
            ALUctrl   = ALU_SUB;
            ImmSrc    = 1'b1;
            PCen      = 1'b1;
            PCsrc     = ~EQ;
            instret_d = instret_q + CNT_WIDTH'(1);
            state_d   = FETCH;
         end

         TRAP: state_d = TRAP;

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM: fetches an instruction via a req/valid handshake, decodes it, and drives the ALU control inputs (ALUctrl, operand-2 select).
- Consumes the ALU EQ flag to resolve branches, and sequences register write-back and PC update.
- Supported ISA subset: addi (ALUctrl 3'b001) and bne (ALUctrl 3'b010, subtract, taken when EQ=0).
- Sits between instruction memory, register file, PC register and ALU in the CPU datapath.

Parameters:
- DATA_WIDTH, 32, instruction/IR width.
- CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request, high in FETCH state
- imem_valid  input  1  fetch data valid this cycle
- imem_rdata  input  DATA_WIDTH  fetched instruction
- instr  output  DATA_WIDTH  current IR contents (fields to regfile/imm-gen)
- EQ  input  1  ALU zero flag
- ALUctrl  output  3  001 add, 010 subtract-with-flag, 000 otherwise
- ALUsrc  output  1  1 = immediate as operand 2, 0 = rs2
- ImmSrc  output  1  0 = I-type imm, 1 = B-type imm
- RegWrite  output  1  regfile write enable
- PCen  output  1  PC register load enable
- PCsrc  output  1  0 = PC+4, 1 = PC+imm
- illegal  output  1  sticky illegal-instruction flag
- instret  output  CNT_WIDTH  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EX_ADDI, WB, EX_BNE, TRAP; state register plus IR, illegal and instret are async-reset.
- Reset values: state IDLE, IR 32'h00000013, illegal 0, instret 0. All outputs 0 while in IDLE, including imem_req and every enable.
- IDLE -> FETCH unconditionally on the first edge after rst_n deasserts.
- FETCH:
  - imem_req=1; all enables 0.
  - If imem_valid: IR <= imem_rdata, go to DECODE.
  - Otherwise stay in FETCH indefinitely, holding imem_req.
- DECODE: all enables 0; ALUctrl 000. Branch on IR:
  - opcode 7'b0010011 with funct3 000 -> EX_ADDI.
  - opcode 7'b1100011 with funct3 001 -> EX_BNE.
  - Anything else -> TRAP.
- EX_ADDI: ALUctrl 001, ALUsrc 1, ImmSrc 0; enables 0; -> WB.
- WB:
  - ALUctrl 001, ALUsrc 1, ImmSrc 0 held.
  - RegWrite = (IR[11:7] != 0).
  - PCen 1, PCsrc 0.
  - instret++; -> FETCH.
- EX_BNE:
  - ALUctrl 010, ALUsrc 0, ImmSrc 1, RegWrite 0, PCen 1.
  - PCsrc = ~EQ, combinational from EQ in this state only.
  - instret++; -> FETCH.
- TRAP: illegal=1 (set on entry edge); all enables and imem_req 0; remains until reset. Only reset clears illegal.
- Latency: addi 4 cycles (FETCH with immediate valid, DECODE, EX_ADDI, WB); bne 3 cycles; each extra FETCH wait cycle adds 1.
- Exactly one PCen pulse per retired instruction. RegWrite is never high outside WB.
- instret wraps from all-ones to 0 with no flag.
- imem_rdata is ignored when imem_valid=0. IR is updated only on a FETCH-state valid cycle, and is held stable outside FETCH.
- rst_n low at any point, mid-instruction included, forces IDLE and the reset values immediately, asynchronously. No partial RegWrite/PCen may follow.
- EQ is ignored in all states except EX_BNE.

Test Plan:
- Reset then imem_valid=1 with 0x00700293 (addi x5,x0,7) -> sequence FETCH, DECODE, EX_ADDI, WB. WB shows ALUctrl 001, ALUsrc 1, RegWrite 1, PCen 1, PCsrc 0. instret 0->1.
- 0x00209463 (bne x1,x2,8) with EQ=0 in EX_BNE -> ALUctrl 010, ALUsrc 0, ImmSrc 1, PCen 1, PCsrc 1, RegWrite 0. Repeat with EQ=1 -> PCsrc 0.
- imem_valid low for 5 cycles in FETCH -> imem_req held 1, IR unchanged, no enables. Valid on 6th cycle -> capture and DECODE next.
- 0x00000033 (add) -> TRAP, illegal=1, imem_req 0 for 20 cycles. rst_n pulse low -> illegal 0, IDLE, then FETCH.
- addi with rd=0 (0x00700013) -> WB with RegWrite 0, PCen 1, instret increments.
- rst_n asserted during WB of addi -> RegWrite and PCen drop in the same cycle, instret 0. With CNT_WIDTH=4, 16 retirements -> instret wraps to 0.
